// File: rtl/ysyx_22050019_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050019_wb_arbiter
// Purpose  : Shares the single register-file write port between the ALU/EXU
//            writeback stream and the LSU load-data stream. Keeps a scoreboard
//            of registers with an outstanding load and raises a read-after-
//            write stall towards decode.
// Ports    :
//   clk_i           clock, all state on the rising edge
//   rst_ni          asynchronous reset, active low
//   alu_valid_i     ALU writeback request        / alu_ready_o  accepted
//   alu_waddr_i     ALU destination register     / alu_wdata_i  ALU result
//   lsu_valid_i     load writeback request       / lsu_ready_o  accepted
//   lsu_waddr_i     load destination register    / lsu_wdata_i  load data
//   ld_issue_i      pulse: a load was issued to ld_issue_rd_i
//   raddr1_i/2_i    decode operand read addresses
//   raw_stall_o     decode must stall (operand not yet in the regfile)
//   regs_wen_o / regs_waddr_o / regs_wdata_o   registered regfile write port
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22050019_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  ld_issue_i,
    input  logic [ADDR_WIDTH-1:0] ld_issue_rd_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic                  raw_stall_o,
    output logic                  regs_wen_o,
    output logic [ADDR_WIDTH-1:0] regs_waddr_o,
    output logic [DATA_WIDTH-1:0] regs_wdata_o
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam int CW    = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_LAST = CW'(STARVE_MAX - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(STARVE_MAX);

    typedef enum logic [0:0] {
        PRIO_LSU = 1'b0,
        PRIO_ALU = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         starve_q, starve_d;
    logic [NREGS-1:0]      busy_q, busy_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic alu_gnt;
    logic lsu_gnt;
    logic alu_blocked;

    // An ALU result must not land before an older load to the same register,
    // otherwise the load would later overwrite the newer value.
    assign alu_blocked = (alu_waddr_i != '0) && busy_q[alu_waddr_i];

    // ------------------------------------------------------------------
    // Arbitration FSM: next state, starvation counter and grants
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        alu_gnt  = 1'b0;
        lsu_gnt  = 1'b0;
        case (state_q)
            PRIO_LSU: begin
                if (lsu_valid_i) begin
                    lsu_gnt = 1'b1;
                end else if (alu_valid_i && !alu_blocked) begin
                    alu_gnt = 1'b1;
                end
                if (alu_valid_i && !alu_gnt) begin
                    if (starve_q == C_LAST) begin
                        state_d = PRIO_ALU;
                    end
                    if (starve_q != C_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            PRIO_ALU: begin
                if (alu_valid_i && !alu_blocked) begin
                    alu_gnt = 1'b1;
                    state_d = PRIO_LSU;
                end else if (lsu_valid_i) begin
                    // ALU is waiting on a load (or gone): keep the port busy.
                    lsu_gnt = 1'b1;
                end
                if (!alu_valid_i) begin
                    state_d  = PRIO_LSU;
                    starve_d = '0;
                end
            end
            default: begin
                state_d = PRIO_LSU;
            end
        endcase
        if (alu_gnt) begin
            starve_d = '0;
        end
    end

    assign alu_ready_o = alu_gnt && rst_ni;
    assign lsu_ready_o = lsu_gnt && rst_ni;

    // ------------------------------------------------------------------
    // Load scoreboard: set on issue wins over a clear on the same edge
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (lsu_gnt && (lsu_waddr_i != '0)) begin
            busy_d[lsu_waddr_i] = 1'b0;
        end
        if (ld_issue_i && (ld_issue_rd_i != '0)) begin
            busy_d[ld_issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registered write port. Writes to x0 are accepted but never enabled.
    // ------------------------------------------------------------------
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_gnt) begin
            wen_d   = (alu_waddr_i != '0);
            waddr_d = alu_waddr_i;
            wdata_d = alu_wdata_i;
        end else if (lsu_gnt) begin
            wen_d   = (lsu_waddr_i != '0);
            waddr_d = lsu_waddr_i;
            wdata_d = lsu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= PRIO_LSU;
            starve_q <= '0;
            busy_q   <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign regs_wen_o   = wen_q;
    assign regs_waddr_o = waddr_q;
    assign regs_wdata_o = wdata_q;

    // ------------------------------------------------------------------
    // RAW stall: operand is pending a load, or is being written this cycle
    // (the regfile only takes the write at the next edge).
    // ------------------------------------------------------------------
    logic stall1;
    logic stall2;

    assign stall1 = (raddr1_i != '0) &&
                    (busy_q[raddr1_i] || (wen_q && (waddr_q == raddr1_i)));
    assign stall2 = (raddr2_i != '0) &&
                    (busy_q[raddr2_i] || (wen_q && (waddr_q == raddr2_i)));
    assign raw_stall_o = stall1 || stall2;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050019_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050019_wb_arbiter
// Purpose  : Self-checking bench for the writeback arbiter: directed scenarios
//            with literal expectations, then randomized traffic compared every
//            cycle against a behavioural model of the arbitration rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050019_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_waddr;
    logic [DW-1:0] alu_wdata;
    logic          lsu_valid, lsu_ready;
    logic [AW-1:0] lsu_waddr;
    logic [DW-1:0] lsu_wdata;
    logic          ld_issue;
    logic [AW-1:0] ld_issue_rd;
    logic [AW-1:0] raddr1, raddr2;
    logic          raw_stall;
    logic          regs_wen;
    logic [AW-1:0] regs_waddr;
    logic [DW-1:0] regs_wdata;

    ysyx_22050019_wb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SM)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready),
        .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
        .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .ld_issue_i(ld_issue), .ld_issue_rd_i(ld_issue_rd),
        .raddr1_i(raddr1), .raddr2_i(raddr2),
        .raw_stall_o(raw_stall),
        .regs_wen_o(regs_wen), .regs_waddr_o(regs_waddr), .regs_wdata_o(regs_wdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    bit            m_busy [32];
    int            m_losses;      // consecutive ALU losses since last ALU win
    bit            m_alu_first;   // ALU has earned priority
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            g_alu, g_lsu;  // model grants for the current cycle

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_losses    = 0;
        m_alu_first = 1'b0;
        m_wen       = 1'b0;
        m_waddr     = '0;
        m_wdata     = '0;
        g_alu       = 1'b0;
        g_lsu       = 1'b0;
    endtask

    function automatic bit hazard(input logic [AW-1:0] ra);
        return (ra != 0) && (m_busy[ra] || (m_wen && m_waddr == ra));
    endfunction

    // Compare every DUT output against the model, 1 time unit after the
    // inputs were applied on the falling edge.
    task automatic check_model();
        bit blk;
        #1;
        blk = (alu_waddr != 0) && m_busy[alu_waddr];
        if (!rst_n) begin
            g_alu = 1'b0;
            g_lsu = 1'b0;
        end else if (m_alu_first) begin
            g_alu = alu_valid && !blk;
            g_lsu = lsu_valid && !g_alu;
        end else begin
            g_lsu = lsu_valid;
            g_alu = alu_valid && !blk && !lsu_valid;
        end
        chk("alu_ready", alu_ready, g_alu);
        chk("lsu_ready", lsu_ready, g_lsu);
        chk("regs_wen", regs_wen, m_wen);
        chk("regs_waddr", regs_waddr, m_waddr);
        chk("regs_wdata", regs_wdata, m_wdata);
        chk("raw_stall", raw_stall, hazard(raddr1) || hazard(raddr2));
    endtask

    // Apply the rising edge to the model, then move to the next falling edge.
    task automatic advance();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (g_alu) begin
                m_wen = (alu_waddr != 0); m_waddr = alu_waddr; m_wdata = alu_wdata;
            end else if (g_lsu) begin
                m_wen = (lsu_waddr != 0); m_waddr = lsu_waddr; m_wdata = lsu_wdata;
            end else begin
                m_wen = 1'b0;
            end
            if (g_lsu && lsu_waddr != 0) m_busy[lsu_waddr] = 1'b0;
            if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
            if (g_alu) begin
                m_losses = 0; m_alu_first = 1'b0;
            end else if (m_alu_first) begin
                if (!alu_valid) begin
                    m_losses = 0; m_alu_first = 1'b0;
                end
            end else if (alu_valid) begin
                m_losses++;
                if (m_losses >= SM) m_alu_first = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit av, input int aa, input logic [63:0] ad,
                         input bit lv, input int la, input logic [63:0] ldd,
                         input bit li, input int lr, input int r1, input int r2);
        alu_valid = av; alu_waddr = AW'(aa); alu_wdata = ad;
        lsu_valid = lv; lsu_waddr = AW'(la); lsu_wdata = ldd;
        ld_issue = li;  ld_issue_rd = AW'(lr);
        raddr1 = AW'(r1); raddr2 = AW'(r2);
    endtask

    task automatic idle(input int r1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(0);
        model_reset();
        repeat (2) begin
            check_model();
            advance();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle(0);
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: ALU only
        drive(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("t1 alu_ready", alu_ready, 1); advance();
        idle(0); check_model();
        chk("t1 wen", regs_wen, 1); chk("t1 waddr", regs_waddr, 5);
        chk("t1 wdata", regs_wdata, 64'h1234); advance();

        // 2: collision, LSU first then ALU
        drive(1, 7, 64'hA, 1, 8, 64'hB, 0, 0, 0, 0); check_model();
        chk("t2 lsu_ready", lsu_ready, 1); chk("t2 alu_ready0", alu_ready, 0); advance();
        drive(1, 7, 64'hA, 0, 0, 0, 0, 0, 0, 0); check_model();
        chk("t2 alu_ready1", alu_ready, 1); chk("t2 first addr", regs_waddr, 8);
        chk("t2 first data", regs_wdata, 64'hB); advance();
        idle(0); check_model();
        chk("t2 second addr", regs_waddr, 7); chk("t2 second data", regs_wdata, 64'hA); advance();

        // 3: starvation, ALU force-granted on the fourth cycle
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 9, 64'h99, 1, 11, 64'(k), 0, 0, 0, 0); check_model();
            chk("t3 alu_ready", alu_ready, (k == 4));
            chk("t3 lsu_ready", lsu_ready, (k != 4));
            advance();
        end
        idle(0); check_model(); advance();

        // 4: scoreboard blocks the ALU until the load lands
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 10, 0, 0); check_model(); advance();
        drive(1, 10, 64'h77, 0, 0, 0, 0, 0, 10, 0); check_model();
        chk("t4 stall", raw_stall, 1); chk("t4 alu blocked", alu_ready, 0); advance();
        drive(1, 10, 64'h77, 1, 10, 64'h55, 0, 0, 10, 0); check_model();
        chk("t4 lsu_ready", lsu_ready, 1); chk("t4 alu still blocked", alu_ready, 0); advance();
        drive(1, 10, 64'h77, 0, 0, 0, 0, 0, 10, 0); check_model();
        chk("t4 load wen", regs_wen, 1); chk("t4 load data", regs_wdata, 64'h55);
        chk("t4 stall on wen", raw_stall, 1); chk("t4 alu granted", alu_ready, 1); advance();
        idle(10); check_model();
        chk("t4 alu data", regs_wdata, 64'h77); advance();
        idle(10); check_model();
        chk("t4 stall cleared", raw_stall, 0); advance();

        // 5: x0 write and same-edge issue/clear
        do_reset();
        drive(0, 0, 0, 1, 0, 64'hDEAD, 0, 0, 0, 0); check_model();
        chk("t5 x0 ready", lsu_ready, 1); advance();
        idle(0); check_model();
        chk("t5 x0 wen", regs_wen, 0); advance();
        drive(0, 0, 0, 0, 0, 0, 1, 3, 0, 0); check_model(); advance();
        drive(0, 0, 0, 1, 3, 64'h33, 1, 3, 3, 0); check_model();
        chk("t5 lsu_ready", lsu_ready, 1); advance();
        idle(3); check_model(); advance();
        idle(3); check_model();
        chk("t5 busy kept", raw_stall, 1); chk("t5 wen idle", regs_wen, 0); advance();

        // 6: reset in the middle of operation
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 4, 0, 0); check_model(); advance();
        drive(1, 6, 64'h66, 0, 0, 0, 0, 0, 0, 0); check_model(); advance();
        drive(1, 2, 64'h22, 0, 0, 0, 0, 0, 4, 0); check_model();
        chk("t6 wen before", regs_wen, 1);
        rst_n = 1'b0;
        #1;
        chk("t6 wen", regs_wen, 0); chk("t6 waddr", regs_waddr, 0);
        chk("t6 wdata", regs_wdata, 0); chk("t6 stall", raw_stall, 0);
        chk("t6 alu_ready", alu_ready, 0);
        model_reset(); advance();
        drive(1, 2, 64'h22, 1, 12, 64'hC, 0, 0, 4, 0); check_model(); advance();
        rst_n = 1'b1;
        check_model();
        chk("t6 prio lsu", lsu_ready, 1); chk("t6 alu waits", alu_ready, 0); advance();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (!alu_valid || g_alu) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_waddr = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 31));
                alu_wdata = {$urandom, $urandom};
            end else if ($urandom_range(0, 49) == 0) begin
                alu_valid = 1'b0;
            end
            if (!lsu_valid || g_lsu) begin
                int r;
                int pick;
                r = $urandom_range(0, 31);
                pick = r;
                if ($urandom_range(0, 3) != 0) begin
                    for (int j = 0; j < 32; j++) begin
                        if (m_busy[(r + j) % 32]) begin
                            pick = (r + j) % 32;
                            break;
                        end
                    end
                end
                lsu_valid = ($urandom_range(0, 9) < 4);
                lsu_waddr = AW'(pick);
                lsu_wdata = {$urandom, $urandom};
            end
            ld_issue    = ($urandom_range(0, 3) == 0);
            ld_issue_rd = AW'($urandom_range(0, 31));
            if (m_busy[ld_issue_rd] && $urandom_range(0, 7) != 0) ld_issue = 1'b0;
            raddr1 = AW'($urandom_range(0, 31));
            raddr2 = AW'($urandom_range(0, 31));
            check_model();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
